// File: rtl/rol_pkg.sv
// Shared types and widths for the rotate unit and its barrel core.
package rol_pkg;

  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;

  typedef logic [WIDTH-1:0]   word_t;
  typedef logic [SHAMT_W-1:0] shamt_t;

endpackage

// File: rtl/rol_barrel_core.sv
// Purely combinational log-depth left rotator: stage k rotates by 2^k when
// numRotates[k] is set, otherwise passes its input straight through.
module rol_barrel_core
  import rol_pkg::*;
(
  input  word_t  a,
  input  shamt_t numRotates,
  output word_t  rotated
);

  word_t stg [0:SHAMT_W];

  assign stg[0] = a;

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    localparam int SH = 1 << k;
    word_t rot_k;
    assign rot_k      = {stg[k][WIDTH-SH-1:0], stg[k][WIDTH-1:WIDTH-SH]};
    assign stg[k+1]   = numRotates[k] ? rot_k : stg[k];
  end

  assign rotated = stg[SHAMT_W];

endmodule

// File: rtl/rol_32_bit.sv
// Registered 32-bit rotate unit (one-cycle latency, valid flag).
// Optional right rotate via the dir port when ROL_32_BIT_ROR_EN is defined.
module rol_32_bit
  import rol_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   in_valid,
  input  word_t  a,
  input  shamt_t numRotates,
`ifdef ROL_32_BIT_ROR_EN
  input  logic   dir,
`endif
  output word_t  z,
  output logic   out_valid
);

  shamt_t amt;
  word_t  rot;
  word_t  z_d, z_q;
  logic   vld_d, vld_q;

`ifdef ROL_32_BIT_ROR_EN
  // Right rotate by n is a left rotate by (WIDTH - n) mod WIDTH, i.e. -n in SHAMT_W bits.
  assign amt = dir ? shamt_t'(shamt_t'(0) - numRotates) : numRotates;
`else
  assign amt = numRotates;
`endif

  rol_barrel_core u_core (
    .a          (a),
    .numRotates (amt),
    .rotated    (rot)
  );

  always_comb begin
    z_d   = in_valid ? rot : z_q;
    vld_d = in_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_q   <= '0;
      vld_q <= 1'b0;
    end else begin
      z_q   <= z_d;
      vld_q <= vld_d;
    end
  end

  assign z         = z_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_rol_32_bit.sv
// Self-checking bench for rol_32_bit: directed vectors plus randomized compare
// against a concatenate-and-slice rotate model.
module tb_rol_32_bit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] a;
  logic [4:0]  numRotates;
  logic        dir;
  logic [31:0] z;
  logic        out_valid;

  int checks;
  int errors;

  logic [31:0] exp_z;
  logic        exp_v;

  rol_32_bit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .a          (a),
    .numRotates (numRotates),
`ifdef ROL_32_BIT_ROR_EN
    .dir        (dir),
`endif
    .z          (z),
    .out_valid  (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_rot(input logic [31:0] v, input int n, input bit right);
    logic [63:0] t;
    t = {v, v};
    if (right) begin
      t = t >> n;
      return t[31:0];
    end
    t = t << n;
    return t[63:32];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Drive one cycle of inputs at negedge, update the model, check just after posedge.
  task automatic step(input bit v, input logic [31:0] av, input int n, input bit d,
                      input string tag, input bit do_chk);
    bit right;
    @(negedge clk);
    in_valid   = v;
    a          = av;
    numRotates = 5'(n);
    dir        = d;
`ifdef ROL_32_BIT_ROR_EN
    right = d;
`else
    right = 1'b0;
`endif
    @(posedge clk);
    #1;
    if (v) exp_z = ref_rot(av, n, right);
    exp_v = v;
    if (do_chk) begin
      chk({tag, "_z"}, z, exp_z);
      chk({tag, "_vld"}, {31'd0, out_valid}, {31'd0, exp_v});
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    a = '0;
    numRotates = '0;
    dir = 1'b0;
    exp_z = '0;
    exp_v = 1'b0;

    // Held in reset with valid traffic: outputs stay cleared.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a = $urandom;
      numRotates = 5'($urandom_range(0, 31));
      @(posedge clk);
      #1;
      chk("rst_hold_z", z, 32'h0);
      chk("rst_hold_vld", {31'd0, out_valid}, 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;

    step(1, 32'hF000_0000, 4, 0, "dir_f0", 1);
    chk("dir_f0_const", z, 32'h0000_000F);
    step(1, 32'h4000_0000, 3, 0, "dir_40", 1);
    chk("dir_40_const", z, 32'h0000_0002);
    step(1, 32'h1234_5678, 0, 0, "bnd_zero", 1);
    chk("bnd_zero_const", z, 32'h1234_5678);
    step(1, 32'h0000_0001, 31, 0, "bnd_31", 1);
    chk("bnd_31_const", z, 32'h8000_0000);
    step(1, 32'h8000_0000, 1, 0, "bnd_msb", 1);
    chk("bnd_msb_const", z, 32'h0000_0001);

    // Async clear mid-cycle, no clock edge.
    step(1, 32'hDEAD_BEEF, 7, 0, "pre_async", 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_z", z, 32'h0);
    chk("async_vld", {31'd0, out_valid}, 32'd0);
    exp_z = '0;
    exp_v = 1'b0;

    // In-flight valid discarded by reset, first valid after release normal.
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1;
    a = 32'hCAFE_F00D;
    numRotates = 5'd9;
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("inflight_z", z, 32'h0);
    chk("inflight_vld", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    step(1, 32'hCAFE_F00D, 9, 0, "post_rst", 1);

    // Back-to-back valids then idle with changing operands.
    for (int i = 0; i < 6; i++)
      step(1, $urandom, $urandom_range(0, 31), 0, "b2b", 1);
    for (int i = 0; i < 3; i++)
      step(0, $urandom, $urandom_range(0, 31), 0, "idle_hold", 1);

`ifdef ROL_32_BIT_ROR_EN
    step(1, 32'h0000_000F, 4, 1, "ror_r", 1);
    chk("ror_r_const", z, 32'hF000_0000);
    step(1, 32'h0000_000F, 4, 0, "ror_l", 1);
    chk("ror_l_const", z, 32'h0000_00F0);
`endif

    // Randomized compare.
    for (int i = 0; i < 10000; i++)
      step(($urandom_range(0, 7) != 0), $urandom, $urandom_range(0, 31),
           1'($urandom_range(0, 1)), "rand", 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rol_32_bit.md
Name: rol_32_bit

Overview:
Registered 32-bit rotate-left unit for the datapath ALU.
- Rotates operand a left by numRotates (0..31) positions; bits leaving the MSB re-enter at the LSB.
- Result is registered once, with a valid flag.
- Sits beside the other ALU shift/rotate units and feeds the ALU result mux.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a power of two.
- SHAMT_W, 5, rotate-amount width; equals log2(WIDTH).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand/amount qualifier; sampled on rising clk.
- a  input  WIDTH  operand to rotate.
- numRotates  input  SHAMT_W  left-rotate amount, unsigned, 0..WIDTH-1.
- z  output  WIDTH  registered rotate result.
- out_valid  output  1  high for one cycle when z holds a new result.

Behaviour:
- Reset: rst_n low asynchronously forces z = 0 and out_valid = 0, regardless of clk.
  - Release is synchronous in effect: the first capture occurs on the first rising clk with rst_n high.
- Function: z_next = (a << numRotates) | (a >> (WIDTH - numRotates)), taken modulo WIDTH bits.
  - numRotates = 0 yields a unchanged; no special-case shift by WIDTH.
  - All numRotates values 0..31 are legal. Amount is unsigned; no wrap beyond SHAMT_W bits is needed.
- Latency: exactly 1 cycle. On a rising clk with in_valid = 1:
  - z <= rotate(a, numRotates);
  - out_valid <= 1.
- On a rising clk with in_valid = 0:
  - out_valid <= 0;
  - z holds its previous value.
- Throughput: one operation per cycle; back-to-back in_valid pulses each produce a result on the following cycle. No backpressure, no stall input.
- Core: combinational log-depth barrel rotator of SHAMT_W stages. Stage k rotates by 2^k when numRotates[k] = 1, otherwise passes through.
- X handling: inputs with in_valid = 0 must not affect z.
- Reset mid-stream: an asserted rst_n discards any in-flight result. The first valid after release behaves normally.

Optional Feature:
- Macro: ROL_32_BIT_ROR_EN.
- Defined:
  - Adds input port dir (1 bit). dir = 0 rotates left; dir = 1 rotates right by numRotates.
  - Right rotate is implemented as a left rotate by (WIDTH - numRotates) mod WIDTH through the same barrel core. dir is sampled with in_valid.
  - Timing and reset are unchanged.
- Undefined: no dir port; left rotate only; behaviour exactly as above.

Decomposition:
- Shared package rol_pkg holds:
  - localparams WIDTH = 32 and SHAMT_W = 5;
  - typedef word_t (logic [WIDTH-1:0]);
  - typedef shamt_t (logic [SHAMT_W-1:0]).
- One sub-module, rol_barrel_core: purely combinational, inputs a and numRotates, output rotated word, built from SHAMT_W generate stages.
- The top rol_32_bit adds the output register, out_valid, reset, and the optional direction logic.

Test Plan:
- Reset: hold rst_n low, drive in_valid = 1 with random a -> z = 0x00000000, out_valid = 0 throughout; assert async clear mid-cycle with no clk edge.
- a = 0xF0000000, numRotates = 4, in_valid pulse -> next cycle z = 0x0000000F, out_valid = 1.
- a = 0x40000000, numRotates = 3 -> z = 0x00000002.
- Boundaries:
  - a = 0x12345678, numRotates = 0 -> z = 0x12345678;
  - a = 0x00000001, numRotates = 31 -> z = 0x80000000;
  - a = 0x80000000, numRotates = 1 -> z = 0x00000001.
- Back-to-back valids, then in_valid = 0 -> results appear on consecutive cycles; after in_valid drops, out_valid = 0 and z holds the last result. Also run a randomized 10k-vector compare against the reference formula.
- With ROL_32_BIT_ROR_EN: a = 0x0000000F, numRotates = 4, dir = 1 -> z = 0xF0000000; dir = 0 with the same inputs -> z = 0x000000F0.
